// File: rtl/pss_pkg.sv
// ============================================================================
// Module      : pss_pkg
// Description : Shared types and reset defaults for the pattern stream scanner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pss_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] DEF_PATTERN = 4'b1101;
    localparam int         DEF_LEN     = 4;

endpackage

`default_nettype wire

// File: rtl/pattern_match_core.sv
// ============================================================================
// Module      : pattern_match_core
// Description : Serial history register with length-masked pattern compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_match_core #(
    parameter int PAT_W = 4,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             bit_in,
    input  logic             bit_en,
    input  logic             flush,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             hit
);

    localparam int HIST_W = (PAT_W > 1) ? PAT_W - 1 : 1;

    logic [HIST_W-1:0] r_hist;
    logic [LEN_W-1:0]  r_seen;
    logic [HIST_W-1:0] w_hist_next;
    logic [PAT_W-1:0]  w_window;
    logic [PAT_W-1:0]  w_mask;
    logic [LEN_W-1:0]  w_seen_next;

    // The window is the stored history with the bit arriving this cycle appended.
    generate
        if (PAT_W > 1) begin : g_hist_wide
            assign w_window    = {r_hist, bit_in};
            assign w_hist_next = w_window[HIST_W-1:0];
        end else begin : g_hist_single
            assign w_window    = bit_in;
            assign w_hist_next = r_hist;
        end
    endgenerate

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (LEN_W'(i) < len);
        end
    end

    assign w_seen_next = (r_seen >= LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : r_seen + LEN_W'(1);

    assign hit = bit_en && !flush && (len != '0) && (w_seen_next >= len)
                 && (((w_window ^ pattern) & w_mask) == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hist <= '0;
            r_seen <= '0;
        end else if (flush) begin
            r_hist <= '0;
            r_seen <= '0;
        end else if (bit_en) begin
            r_hist <= w_hist_next;
            r_seen <= w_seen_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pattern_stream_scanner.sv
// ============================================================================
// Module      : pattern_stream_scanner
// Description : Serialises words MSB-first and reports overlapping pattern hits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_stream_scanner
    import pss_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         cfg_we,
    input  logic [PAT_W-1:0]             cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         busy,
    output logic                         match,
    output logic [$clog2(DATA_W)-1:0]    match_idx,
    output logic [CNT_W-1:0]             match_count,
    output logic                         cfg_err
);

    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [PAT_W-1:0] c_def_pattern = PAT_W'(DEF_PATTERN);
    localparam logic [LEN_W-1:0] c_def_len     = LEN_W'((DEF_LEN > PAT_W) ? PAT_W : DEF_LEN);
    localparam logic [IDX_W-1:0] c_last_bit    = IDX_W'(DATA_W - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [DATA_W-1:0]  r_word;
    logic [IDX_W-1:0]   r_bit_cnt;
    logic [PAT_W-1:0]   r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_count;
    logic               r_match;
    logic [IDX_W-1:0]   r_match_idx;
    logic               r_cfg_err;

    logic               w_last_bit;
    logic               w_accept;
    logic               w_bit_en;
    logic               w_cfg_load;
    logic               w_flush;
    logic               w_hit;
    logic [LEN_W-1:0]   w_cfg_len;

    assign w_last_bit = (r_state == SHIFT) && (r_bit_cnt == c_last_bit);
    assign in_ready   = !clear && ((r_state == IDLE) || w_last_bit);
    assign w_accept   = in_valid && in_ready;
    assign w_bit_en   = (r_state == SHIFT) && !clear;
    assign w_cfg_load = cfg_we && !clear && (r_state == IDLE) && !w_accept;
    assign w_flush    = clear || w_cfg_load;
    assign w_cfg_len  = (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;

    assign busy        = (r_state == SHIFT);
    assign match       = r_match;
    assign match_idx   = r_match_idx;
    assign match_count = r_count;
    assign cfg_err     = r_cfg_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_accept) w_state_next = SHIFT;
                SHIFT:   if (w_last_bit && !w_accept) w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Word register shifts left so the bit being serialised is always the MSB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word    <= '0;
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_word    <= in_data;
            r_bit_cnt <= '0;
        end else if (w_bit_en) begin
            r_word    <= r_word << 1;
            r_bit_cnt <= r_bit_cnt + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pattern <= c_def_pattern;
            r_len     <= c_def_len;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && !clear && !w_cfg_load;
            if (w_cfg_load) begin
                r_pattern <= cfg_pattern;
                r_len     <= w_cfg_len;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_match     <= 1'b0;
            r_match_idx <= '0;
            r_count     <= '0;
        end else begin
            r_match <= w_hit;
            if (w_hit) begin
                r_match_idx <= r_bit_cnt;
            end
            if (clear) begin
                r_count <= '0;
            end else if (w_hit && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    pattern_match_core #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .bit_in  (r_word[DATA_W-1]),
        .bit_en  (w_bit_en),
        .flush   (w_flush),
        .pattern (r_pattern),
        .len     (r_len),
        .hit     (w_hit)
    );

endmodule

`default_nettype wire
